// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scancode decoder.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int FRM_START = 0;
  localparam int FRM_D0 = 1;
  localparam int FRM_D7 = 8;
  localparam int FRM_PAR = 9;
  localparam int FRM_STOP = 10;
  typedef struct packed {
    logic ext;
    logic rel;
    logic [7:0] code;
  } ps2_event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO with extra-MSB pointers; drop pulses when a push is refused.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // a full queue still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      drop <= push && !do_push;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: validates PS/2 frames, folds E0/F0 prefixes into flags and queues key events.
// Optional PS2_PARITY_CHECK_EN adds the odd-parity check to frame validation.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] frame_in,
  input  logic        frame_valid,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [7:0]  ev_code,
  output logic        ev_extended,
  output logic        ev_release,
  output logic        err_frame,
  output logic        err_overflow
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [WW-1:0] wd;
  logic [7:0] code;
  logic good, timeout, push, is_ext, is_rel, fifo_full, fifo_empty;
  ps2_event_t ev_in, ev_out;
  assign code = frame_in[FRM_D7:FRM_D0];
`ifdef PS2_PARITY_CHECK_EN
  assign good = !frame_in[FRM_START] && frame_in[FRM_STOP] && (^frame_in[FRM_PAR:FRM_D0]);
`else
  assign good = !frame_in[FRM_START] && frame_in[FRM_STOP];
`endif
  assign timeout = wd == WW'(TIMEOUT_CYCLES);
  assign is_ext = state == EXT || state == EXT_BRK;
  assign is_rel = state == BRK || state == EXT_BRK;
  assign ev_in = {is_ext, is_rel, code};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      err_frame <= 1'b0;
    end else begin
      state <= state_n;
      err_frame <= frame_valid && !good;
      wd <= frame_valid ? '0 : (state != IDLE && !timeout) ? wd + 1'b1 : wd;
    end
  end
  // a frame arriving in the same cycle as the timeout still sees its prefix
  always_comb begin
    state_n = state;
    push = 1'b0;
    if (frame_valid) begin
      if (!good) state_n = IDLE;
      else if (code == PS2_EXT) state_n = is_rel ? EXT_BRK : EXT;
      else if (code == PS2_BRK) state_n = is_ext ? EXT_BRK : BRK;
      else begin
        push = 1'b1;
        state_n = IDLE;
      end
    end else if (timeout) state_n = IDLE;
  end
  ps2_event_fifo #(.WIDTH($bits(ps2_event_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .din(ev_in),
    .pop(ev_ready),
    .dout(ev_out),
    .full(fifo_full),
    .empty(fifo_empty),
    .drop(err_overflow)
  );
  assign ev_valid = !fifo_empty;
  assign ev_code = ev_out.code;
  assign ev_extended = ev_out.ext;
  assign ev_release = ev_out.rel;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed and random checks against a prefix-flag/queue reference model.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;
  localparam int TMO = 20;
  logic clk = 0, reset = 1, frame_valid = 0, ev_ready = 0;
  logic [10:0] frame_in = '0;
  logic ev_valid, ev_extended, ev_release, err_frame, err_overflow;
  logic [7:0] ev_code;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_fv = 0;
  logic [9:0] expq[$];
  bit m_ext, m_rel, exp_ef, exp_of;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_extended(ev_extended), .ev_release(ev_release),
    .err_frame(err_frame), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mkf(input logic [7:0] c);
    return {1'b1, ~^c, c, 1'b0};
  endfunction

  function automatic bit good_frame(input logic [10:0] f);
`ifdef PS2_PARITY_CHECK_EN
    return !f[0] && f[10] && (^f[9:1]);
`else
    return !f[0] && f[10];
`endif
  endfunction

  // drive one cycle and advance the model: prefixes are flags, events a bounded queue
  task automatic step(input bit fv, input logic [10:0] f, input bit rdy);
    int sz;
    bit pop;
    logic [7:0] c;
    frame_valid = fv;
    frame_in = f;
    ev_ready = rdy;
    sz = expq.size();
    pop = sz > 0 && rdy;
    exp_ef = 0;
    exp_of = 0;
    if (pop) void'(expq.pop_front());
    if (fv) begin
      if (cyc - last_fv >= TMO + 2) begin m_ext = 0; m_rel = 0; end
      last_fv = cyc;
      c = f[8:1];
      if (!good_frame(f)) begin exp_ef = 1; m_ext = 0; m_rel = 0; end
      else if (c == 8'hE0) m_ext = 1;
      else if (c == 8'hF0) m_rel = 1;
      else begin
        if (sz < DEPTH || pop) expq.push_back({m_ext, m_rel, c});
        else exp_of = 1;
        m_ext = 0;
        m_rel = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    frame_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    frame_valid = 1;
    frame_in = mkf(8'h1C);
    ev_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    frame_valid = 0;
    ev_ready = 0;
    cyc += 2;
    last_fv = cyc;
    expq.delete();
    m_ext = 0; m_rel = 0; exp_ef = 0; exp_of = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ev_valid, ev_code, ev_extended, ev_release, err_frame, err_overflow} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset: got v=%b code=%h e=%b r=%b ef=%b of=%b, want all zero",
               ev_valid, ev_code, ev_extended, ev_release, err_frame, err_overflow);
    end
  endtask

  task automatic test_make();
    step(1, 11'h438, 0);
    n_cmp++;
    if (ev_valid !== 1 || ev_code !== 8'h1C || ev_extended !== 0 || ev_release !== 0) begin
      n_bad++;
      $display("FAIL make: got v=%b code=%h e=%b r=%b, want 1 1c 0 0", ev_valid, ev_code, ev_extended, ev_release);
    end
    step(0, '0, 1);
    n_cmp++;
    if (ev_valid !== 0) begin n_bad++; $display("FAIL make_pop: got v=%b, want 0", ev_valid); end
  endtask

  task automatic test_ext_break();
    step(1, 11'h5C0, 0);
    n_cmp++;
    if (ev_valid !== 0) begin n_bad++; $display("FAIL ext_prefix: got v=%b, want 0", ev_valid); end
    step(1, 11'h7E0, 0);
    n_cmp++;
    if (ev_valid !== 0) begin n_bad++; $display("FAIL brk_prefix: got v=%b, want 0", ev_valid); end
    step(1, 11'h4EA, 0);
    n_cmp++;
    if (ev_valid !== 1 || {ev_extended, ev_release, ev_code} !== 10'h375) begin
      n_bad++;
      $display("FAIL ext_break: got v=%b ev=%h, want 1 375", ev_valid, {ev_extended, ev_release, ev_code});
    end
    step(0, '0, 1);
    n_cmp++;
    if (ev_valid !== 0) begin n_bad++; $display("FAIL ext_break_single: got v=%b, want 0", ev_valid); end
  endtask

  task automatic test_parity();
    step(1, 11'h638, 0);
    n_cmp++;
`ifdef PS2_PARITY_CHECK_EN
    if (err_frame !== 1 || ev_valid !== 0) begin
      n_bad++;
      $display("FAIL parity: got ef=%b v=%b, want 1 0", err_frame, ev_valid);
    end
`else
    if (err_frame !== 0 || ev_valid !== 1 || ev_code !== 8'h1C) begin
      n_bad++;
      $display("FAIL parity_ignored: got ef=%b v=%b code=%h, want 0 1 1c", err_frame, ev_valid, ev_code);
    end
`endif
    step(0, '0, 1);
    n_cmp++;
    if (err_frame !== 0 || ev_valid !== 0) begin
      n_bad++;
      $display("FAIL parity_after: got ef=%b v=%b, want 0 0", err_frame, ev_valid);
    end
  endtask

  task automatic test_bad_stop();
    step(1, 11'h7E0, 0);
    step(1, 11'h038, 0);
    n_cmp++;
    if (err_frame !== 1 || ev_valid !== 0) begin
      n_bad++;
      $display("FAIL bad_stop: got ef=%b v=%b, want 1 0", err_frame, ev_valid);
    end
    step(1, 11'h438, 0);
    n_cmp++;
    if (err_frame !== 0 || ev_valid !== 1 || ev_release !== 0 || ev_extended !== 0 || ev_code !== 8'h1C) begin
      n_bad++;
      $display("FAIL bad_stop_idle: got ef=%b v=%b r=%b e=%b code=%h, want 0 1 0 0 1c",
               err_frame, ev_valid, ev_release, ev_extended, ev_code);
    end
    step(0, '0, 1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      step(1, mkf(8'h10 + 8'(i)), 0);
      n_cmp++;
      if (err_overflow !== (i == 4)) begin
        n_bad++;
        $display("FAIL overflow_%0d: got of=%b, want %b", i, err_overflow, i == 4);
      end
    end
    step(0, '0, 0);
    n_cmp++;
    if (err_overflow !== 0) begin n_bad++; $display("FAIL overflow_pulse: got of=%b, want 0", err_overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ev_valid !== 1 || {ev_extended, ev_release, ev_code} !== {2'b00, 8'h10 + 8'(i)}) begin
        n_bad++;
        $display("FAIL drain_%0d: got v=%b ev=%h, want 1 %h", i, ev_valid, {ev_extended, ev_release, ev_code}, 8'h10 + 8'(i));
      end
      step(0, '0, 1);
    end
    n_cmp++;
    if (ev_valid !== 0) begin n_bad++; $display("FAIL drain_empty: got v=%b, want 0", ev_valid); end
    for (int i = 0; i < 4; i++) step(1, mkf(8'h20 + 8'(i)), 0);
    step(1, mkf(8'h24), 1);
    n_cmp++;
    if (err_overflow !== 0) begin n_bad++; $display("FAIL full_push_pop: got of=%b, want 0", err_overflow); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (ev_valid !== 1 || ev_code !== 8'h20 + 8'(i)) begin
        n_bad++;
        $display("FAIL drain2_%0d: got v=%b code=%h, want 1 %h", i, ev_valid, ev_code, 8'h20 + 8'(i));
      end
      step(0, '0, 1);
    end
  endtask

  task automatic test_watchdog();
    step(1, 11'h7E0, 0);
    repeat (25) step(0, '0, 0);
    step(1, 11'h438, 0);
    n_cmp++;
    if (ev_valid !== 1 || ev_release !== 0 || ev_code !== 8'h1C) begin
      n_bad++;
      $display("FAIL watchdog: got v=%b r=%b code=%h, want 1 0 1c", ev_valid, ev_release, ev_code);
    end
    step(0, '0, 1);
    // gap 21 keeps the prefix, gap 22 loses it
    for (int g = 21; g <= 22; g++) begin
      step(1, 11'h5C0, 0);
      repeat (g - 1) step(0, '0, 0);
      step(1, 11'h438, 0);
      n_cmp++;
      if (ev_valid !== 1 || ev_extended !== (g == 21) || {ev_extended, ev_release, ev_code} !== expq[0]) begin
        n_bad++;
        $display("FAIL watchdog_gap%0d: got v=%b e=%b, want 1 %b", g, ev_valid, ev_extended, g == 21);
      end
      step(0, '0, 1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, mkf(8'h30 + 8'(i)), 0);
    step(1, 11'h5C0, 0);
    step(1, 11'h7E0, 0);
    n_cmp++;
    if (ev_valid !== 1 || ev_code !== 8'h30) begin
      n_bad++;
      $display("FAIL pre_reset: got v=%b code=%h, want 1 30", ev_valid, ev_code);
    end
    do_reset();
    n_cmp++;
    if ({ev_valid, ev_code, ev_extended, ev_release, err_frame, err_overflow} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got v=%b code=%h e=%b r=%b ef=%b of=%b, want all zero",
               ev_valid, ev_code, ev_extended, ev_release, err_frame, err_overflow);
    end
    step(1, 11'h438, 0);
    n_cmp++;
    if (ev_valid !== 1 || ev_extended !== 0 || ev_release !== 0 || ev_code !== 8'h1C) begin
      n_bad++;
      $display("FAIL reset_mid_idle: got v=%b e=%b r=%b code=%h, want 1 0 0 1c", ev_valid, ev_extended, ev_release, ev_code);
    end
    step(0, '0, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[6] = '{8'h1C, 8'hE0, 8'h75, 8'hF0, 8'hE0, 8'h32};
    for (int i = 0; i < 6; i++) begin
      step(1, mkf(seq[i]), 1);
      n_cmp++;
      if (ev_valid !== (expq.size() != 0) || (ev_valid && {ev_extended, ev_release, ev_code} !== expq[0])) begin
        n_bad++;
        $display("FAIL b2b_%0d: got v=%b ev=%h, want %b %h", i, ev_valid, {ev_extended, ev_release, ev_code}, expq.size() != 0, expq[0]);
      end
    end
    step(0, '0, 1);
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [10:0] f;
    bit exp_v;
    int r;
    for (int n = 0; n < 600; n++) begin
      exp_v = expq.size() != 0;
      n_cmp++;
      if (ev_valid !== exp_v || err_frame !== exp_ef || err_overflow !== exp_of ||
          (exp_v && {ev_extended, ev_release, ev_code} !== expq[0])) begin
        n_bad++;
        $display("FAIL random_%0d: got v=%b ev=%h ef=%b of=%b, want %b %h %b %b", n, ev_valid,
                 {ev_extended, ev_release, ev_code}, err_frame, err_overflow, exp_v, expq[0], exp_ef, exp_of);
      end
      r = $urandom_range(0, 9);
      c = r == 0 ? 8'hE0 : r == 1 ? 8'hF0 : r == 2 ? 8'hAA : 8'($urandom);
      f = mkf(c);
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 2);
        f[r == 0 ? 0 : r == 1 ? 9 : 10] = ~f[r == 0 ? 0 : r == 1 ? 9 : 10];
      end
      step($urandom_range(0, 1) == 1, f, $urandom_range(0, 2) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity();
    test_bad_stop();
    test_overflow();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes 11-bit PS/2 frames from the PS/2 capture stage and turns them into key events: it validates framing (start, stop, parity), folds the E0 (extended) and F0 (break) prefix bytes into flags, and queues complete events. Events leave through a valid/ready interface to the keyboard-to-7-segment logic. A watchdog discards a prefix that is left dangling by a dropped byte.

## Interface
- `FIFO_DEPTH`, default 4: event queue depth; must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, default 1_000_000: number of `clk` cycles after a prefix byte before the prefix is abandoned (10 ms at 100 MHz).
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `frame_in` in 11: captured frame. bit0 = start, bits8:1 = data (LSB first, bit1 = D0), bit9 = odd parity, bit10 = stop.
- `frame_valid` in 1: one-cycle strobe; `frame_in` is valid in that cycle.
- `ev_valid` out 1: the event at the queue head is valid.
- `ev_ready` in 1: the consumer accepts the head event.
- `ev_code` out 8: scancode byte.
- `ev_extended` out 1: the event was preceded by E0.
- `ev_release` out 1: the event was preceded by F0 (break).
- `err_frame` out 1: one-cycle pulse when a frame is rejected.
- `err_overflow` out 1: one-cycle pulse when an event is dropped because the queue is full.

## Operation
- A frame is good when start = 0, stop = 1 and parity checks (see Configuration).
- A bad frame:
  - pulses `err_frame`;
  - returns the FSM to IDLE;
  - is not queued.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
- Transitions on a good frame:
  - IDLE: E0 → EXT; F0 → BRK; any other byte → push {ext=0, rel=0, code}, stay IDLE.
  - EXT: F0 → EXT_BRK; E0 → EXT; other → push {1, 0, code}, go to IDLE.
  - BRK: F0 → BRK; E0 → EXT_BRK; other → push {0, 1, code}, go to IDLE.
  - EXT_BRK: E0 or F0 → EXT_BRK; other → push {1, 1, code}, go to IDLE.
- E1, AA, FA, EE and FF are ordinary codes and are pushed like any other byte.
- Watchdog:
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
  - It clears on every `frame_valid` and counts while the FSM is not in IDLE, saturating.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE. No event and no error are produced.
- Queue:
  - Event word is 10 bits: {ext, rel, code}.
  - A pop happens when `ev_valid && ev_ready`.
  - A push into a full queue is accepted only if a pop happens in the same cycle; otherwise the event is dropped and `err_overflow` pulses.
  - Push and pop together on an empty queue: the pushed event becomes the head in the next cycle.
- Pointers are log2(FIFO_DEPTH) + 1 bits wide, using the extra-MSB full/empty scheme, and wrap naturally.

## Timing
- `frame_valid` in cycle N:
  - FSM state and the queue update at the edge ending N;
  - `ev_valid` and `ev_*` are visible in N+1 when the queue was empty;
  - `err_frame` and `err_overflow` are high only in N+1.
- `ev_code`, `ev_extended` and `ev_release` are stable while `ev_valid && !ev_ready`.
- When `ev_valid` is low, `ev_code`, `ev_extended` and `ev_release` are don't-care.
- Reset values: `ev_valid` = 0, `ev_code` = 8'h00, `ev_extended` = 0, `ev_release` = 0, `err_frame` = 0, `err_overflow` = 0, FSM = IDLE, queue empty, watchdog = 0.
- Reset asserted mid-sequence (for example in EXT_BRK with 3 events queued) flushes everything. A `frame_valid` during reset is ignored.
- Only one frame can arrive per `frame_valid` strobe. The design has no throughput limit: back-to-back strobes on consecutive cycles are handled.

## Configuration
- Macro: `PS2_PARITY_CHECK_EN`.
- Defined: a good frame also requires odd parity over bits 9:1, that is `^frame_in[9:1] == 1`.
- Undefined: bit9 is ignored. Only start and stop are checked.

## Structure
- The shared package `ps2_pkg` holds:
  - the FSM state enum;
  - the prefix constants `PS2_EXT = 8'hE0` and `PS2_BRK = 8'hF0`;
  - the frame bit-position constants;
  - the event struct {ext, rel, code}.
- One sub-module, `ps2_event_fifo`: a synchronous FIFO parameterised by width and depth, with push/pop, full/empty and a drop flag.
- Frame validation, the FSM and the watchdog live in the top module.

## Test plan
- Make code 0x1C: `frame_in` = 11'h438 with `frame_valid` → in N+1, `ev_valid` = 1, `ev_code` = 1C, ext = 0, rel = 0.
- Break of an extended key: frames 11'h5C0 (E0), then 11'h7E0 (F0), then 11'h4EA (0x75) → a single event: code 75, ext = 1, rel = 1. No event is produced for the prefix bytes.
- Parity error: 11'h638 (0x1C with parity flipped) → `err_frame` pulses and nothing is queued. With `PS2_PARITY_CHECK_EN` undefined, the same frame is accepted as code 1C.
- Bad stop bit: 11'h038 → `err_frame` pulses. If sent after F0, the FSM is back in IDLE, and a following 11'h438 produces a make event (rel = 0).
- Overflow: hold `ev_ready` = 0 and send 5 make codes with FIFO_DEPTH = 4 → the 5th raises `err_overflow`. The queue then drains the first 4 in order. Repeat with `ev_ready` = 1 in the cycle the 5th event is pushed → no drop.
- Watchdog: TIMEOUT_CYCLES = 20, send F0, wait 25 cycles, then send 11'h438 → a make event, rel = 0. Separately, reset asserted while in EXT_BRK with a non-empty queue → all outputs return to their reset values.
